// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: decode-queue entry layout and defaults
package cpu_types_pkg;

  localparam int DQ_DEPTH_DEFAULT = 4;
  localparam int DQ_WORD_W        = 32;
  localparam int DQ_REG_W         = 5;
  localparam int DQ_CTRL_W        = 24;

  typedef struct packed {
    logic [DQ_WORD_W-1:0] pc;
    logic [DQ_WORD_W-1:0] inst;
    logic [DQ_CTRL_W-1:0] ctrl;
    logic                 halt;
    logic [DQ_REG_W-1:0]  rs;
    logic [DQ_REG_W-1:0]  rt;
    logic [DQ_WORD_W-1:0] rdat1;
    logic [DQ_WORD_W-1:0] rdat2;
  } dq_entry_t;

endpackage

// File: rtl/decode_issue_queue_if.sv
// rtl/decode_issue_queue_if.sv - decode/execute/writeback bundle; stats ports under DECODE_QUEUE_STATS_EN
interface decode_issue_queue_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 24,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_inst;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_halt;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rt;
  logic [WORD_W-1:0] in_rdat1;
  logic [WORD_W-1:0] in_rdat2;
  logic              wb_wen;
  logic [REG_W-1:0]  wb_sel;
  logic [WORD_W-1:0] wb_dat;
  logic              flush;
  logic              load_use;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_inst;
  logic [WORD_W-1:0] out_pp4;
  logic [WORD_W-1:0] out_signext;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_W-1:0]  out_rs;
  logic [REG_W-1:0]  out_rt;
  logic [WORD_W-1:0] out_rdat1;
  logic [WORD_W-1:0] out_rdat2;
  logic [CNT_W-1:0]  count;
  logic              halted;
`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       flush_cnt;
`endif

  modport master (
    output in_valid, in_pc, in_inst, in_ctrl, in_halt, in_rs, in_rt, in_rdat1, in_rdat2,
    output wb_wen, wb_sel, wb_dat, flush, load_use, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_pp4, out_signext, out_ctrl,
    input  out_rs, out_rt, out_rdat1, out_rdat2, count, halted
`ifdef DECODE_QUEUE_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_ctrl, in_halt, in_rs, in_rt, in_rdat1, in_rdat2,
    input  wb_wen, wb_sel, wb_dat, flush, load_use, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_pp4, out_signext, out_ctrl,
    output out_rs, out_rt, out_rdat1, out_rdat2, count, halted
`ifdef DECODE_QUEUE_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/dq_ptr_ctrl.sv
// rtl/dq_ptr_ctrl.sv - read/write pointers and occupancy for the decode issue queue
module dq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  // DEPTH is a power of two, so natural pointer overflow is the wrap
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - in-order decode-to-execute queue with writeback refresh, flush, bubble, halt
// Optional counters stall_cnt/flush_cnt are built when DECODE_QUEUE_STATS_EN is defined.
module decode_issue_queue
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = DQ_WORD_W,
  parameter int REG_W  = DQ_REG_W,
  parameter int CTRL_W = DQ_CTRL_W,
  parameter int DEPTH  = DQ_DEPTH_DEFAULT
) (
  input logic                 CLK,
  input logic                 RST,
  decode_issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
    logic [CTRL_W-1:0] ctrl;
    logic              halt;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [WORD_W-1:0] rdat1;
    logic [WORD_W-1:0] rdat2;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             halted;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  logic             wb_hit;

  assign in_ready  = !RST && !full && !halted && !bus.flush && !bus.load_use;
  assign out_valid = !RST && !empty && !bus.load_use && !bus.flush;
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;
  assign wb_hit    = bus.wb_wen && (bus.wb_sel != '0);

  dq_ptr_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_ptr (
    .clk    (CLK),
    .rst    (RST),
    .push   (push),
    .pop    (pop),
    .flush  (bus.flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // An entry entering in the same cycle as its producer's writeback captures the new value
  always_comb begin
    in_entry       = '0;
    in_entry.pc    = bus.in_pc;
    in_entry.inst  = bus.in_inst;
    in_entry.ctrl  = bus.in_ctrl;
    in_entry.halt  = bus.in_halt;
    in_entry.rs    = bus.in_rs;
    in_entry.rt    = bus.in_rt;
    in_entry.rdat1 = (wb_hit && bus.in_rs == bus.wb_sel) ? bus.wb_dat : bus.in_rdat1;
    in_entry.rdat2 = (wb_hit && bus.in_rt == bus.wb_sel) ? bus.wb_dat : bus.in_rdat2;
  end

  // Stale slots may be refreshed too; they are overwritten before becoming visible
  always_ff @(posedge CLK) begin
    if (!RST && !bus.flush) begin
      if (wb_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].rs == bus.wb_sel) mem[i].rdat1 <= bus.wb_dat;
          if (mem[i].rt == bus.wb_sel) mem[i].rdat2 <= bus.wb_dat;
        end
      end
      if (push) mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || bus.flush) halted <= 1'b0;
    else if (push && bus.in_halt) halted <= 1'b1;
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = head.pc;
  assign bus.out_inst    = head.inst;
  assign bus.out_pp4     = out_valid ? head.pc + WORD_W'(4) : '0;
  assign bus.out_signext = {{(WORD_W-16){head.inst[15]}}, head.inst[15:0]};
  assign bus.out_ctrl    = head.ctrl;
  assign bus.out_rs      = head.rs;
  assign bus.out_rt      = head.rt;
  assign bus.out_rdat1   = head.rdat1;
  assign bus.out_rdat2   = head.rdat2;
  assign bus.count       = count;
  assign bus.halted      = halted;

`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt} + 33'(count);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.in_valid && !in_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 1'b1;
      if (bus.flush) flush_cnt <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
`endif

endmodule
